mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_defs_pkg.sv | 19 +
 rtl/arb_lat_counter.sv | 26 ++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, default timing
// parameters and the byte-to-word address helper.
package mips_defs;

  localparam int DEF_LATENCY    = 2;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Memory latency countdown: loaded when the RAM strobe is issued, decremented
// while waiting, zero flag marks the cycle whose edge samples read data.
module arb_lat_counter (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [2:0] r_count;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end
  end

  assign o_zero = (r_count == 3'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port RAM.
// Data normally wins; a bounded starvation counter guarantees fetch progress.
module mem_arbiter
  import mips_defs::*;
#(
  parameter int LATENCY    = DEF_LATENCY,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  localparam logic [2:0] LAT_LOAD   = 3'(LATENCY - 1);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_t  r_state;
  logic        r_win_data;
  logic        r_we;
  logic        r_mem_en;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_if_ready;
  logic        r_dm_ready;
  logic [2:0]  r_starve;

  logic w_any_req;
  logic w_pick_data;
  logic w_lat_load;
  logic w_lat_dec;
  logic w_lat_zero;

  assign w_any_req   = if_req | dm_req;
  assign w_pick_data = dm_req & ~(if_req & (r_starve == STARVE_LIM));
  assign w_lat_load  = (r_state == ST_GRANT);
  assign w_lat_dec   = (r_state == ST_WAIT) & ~w_lat_zero;

  // Counter holds LATENCY-1 after the strobe edge, so zero lands on the
  // cycle whose closing edge is LATENCY cycles after the RAM saw mem_en.
  arb_lat_counter u_lat (
    .clk        (clk),
    .i_reset    (reset),
    .i_load     (w_lat_load),
    .i_load_val (LAT_LOAD),
    .i_dec      (w_lat_dec),
    .o_zero     (w_lat_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_win_data  <= 1'b0;
      r_we        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
    end else begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_win_data  <= w_pick_data;
            r_we        <= w_pick_data & dm_we;
            r_mem_addr  <= word_addr(w_pick_data ? dm_addr : if_addr);
            r_mem_wdata <= w_pick_data ? dm_wdata : 32'd0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_pick_data & dm_we;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_lat_zero) begin
            if (r_win_data) begin
              if (!r_we) r_dm_rdata <= mem_rdata;
              r_dm_ready <= 1'b1;
            end else begin
              r_if_rdata <= mem_rdata;
              r_if_ready <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end
        // Requesters may still show req while ready is high; skip that cycle.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !if_req) begin
      r_starve <= '0;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      if (!w_pick_data) begin
        r_starve <= '0;
      end else if (r_starve < STARVE_LIM) begin
        r_starve <= r_starve + 3'd1;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;
  assign stall     = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-accurate RAM model.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we, stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall     (stall)
  );

  // RAM model: samples mem_en on a rising edge, read data valid LAT edges later.
  logic [31:0] ram [0:255];
  logic [31:0] rd_pipe [0:LAT-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      rd_pipe[0] <= ram[mem_addr[7:0]];
    end else begin
      rd_pipe[0] <= 32'h0BAD0BAD;
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  always @(negedge clk) begin
    if (!reset) begin
      if (if_ready) $display("xact fetch done if_rdata=%h", if_rdata);
      if (dm_ready) $display("xact data  done dm_rdata=%h", dm_rdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rdy(input bit data_side, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(data_side ? dm_ready : if_ready) && cycles < 30);
    chk(data_side ? "dm_rdy_wait" : "if_rdy_wait",
        {31'b0, (data_side ? dm_ready : if_ready)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  n_data;
    bit  first_seen, data_done, got_if, stall_gap, stray;

    for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    ram[0]    <= 32'h20080001;
    ram[1]    <= 32'h11111111;
    ram[8'h10] <= 32'hCAFEF00D;

    reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_mem_en",   {31'b0, mem_en},   32'd0);
    chk("rst_mem_we",   {31'b0, mem_we},   32'd0);
    chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
    chk("rst_dm_ready", {31'b0, dm_ready}, 32'd0);
    chk("rst_mem_addr", mem_addr,  32'd0);
    chk("rst_if_rdata", if_rdata,  32'd0);

    // Fetch 0x00: one-cycle strobe, ready LATENCY+1 cycles after acceptance
    if_req = 1; if_addr = 32'h0;
    tick();
    chk("t1_mem_en",   {31'b0, mem_en}, 32'd1);
    chk("t1_mem_we",   {31'b0, mem_we}, 32'd0);
    chk("t1_mem_addr", mem_addr,        32'h0);
    chk("t1_stall",    {31'b0, stall},  32'd1);
    tick();
    chk("t1_mem_en_off", {31'b0, mem_en}, 32'd0);
    tick();
    chk("t1_early_rdy", {31'b0, if_ready}, 32'd0);
    tick();
    chk("t1_if_ready", {31'b0, if_ready}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h20080001);
    chk("t1_stall_end", {31'b0, stall}, 32'd0);
    if_req = 0;
    tick();
    chk("t1_rdy_pulse", {31'b0, if_ready}, 32'd0);
    tick();

    // Simultaneous fetch 0x04 and data read 0x40: data first
    if_req = 1; if_addr = 32'h4; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    first_seen = 0; data_done = 0; got_if = 0; stall_gap = 0;
    for (int c = 0; c < 40 && !got_if; c++) begin
      tick();
      if (mem_en && !first_seen) begin
        first_seen = 1;
        chk("t2_first_addr", mem_addr, 32'h10);
      end
      if (dm_ready) begin
        data_done = 1;
        chk("t2_dm_rdata", dm_rdata, 32'hCAFEF00D);
        dm_req = 0;
      end
      if (if_ready) begin
        got_if = 1;
        chk("t2_order", {31'b0, data_done}, 32'd1);
        chk("t2_if_rdata", if_rdata, 32'h11111111);
        if_req = 0;
      end else if (!stall) begin
        stall_gap = 1;
      end
    end
    chk("t2_if_done",    {31'b0, got_if},    32'd1);
    chk("t2_stall_hold", {31'b0, stall_gap}, 32'd0);
    tick();

    // Write 0xDEADBEEF to 0x40, then read it back
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    tick();
    chk("t3_wr_en",    {31'b0, mem_en}, 32'd1);
    chk("t3_wr_we",    {31'b0, mem_we}, 32'd1);
    chk("t3_wr_addr",  mem_addr,        32'h10);
    chk("t3_wr_wdata", mem_wdata,       32'hDEADBEEF);
    wait_rdy(1'b1, cyc);
    chk("t3_wr_keeps_rdata", dm_rdata, 32'hCAFEF00D);
    dm_req = 0; dm_we = 0;
    tick();
    dm_req = 1;
    wait_rdy(1'b1, cyc);
    chk("t3_rd_rdata", dm_rdata, 32'hDEADBEEF);
    dm_req = 0;
    tick();

    // Both held: fetch wins after exactly four data grants
    if_req = 1; if_addr = 32'h0; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    n_data = 0; got_if = 0;
    for (int c = 0; c < 80 && !got_if; c++) begin
      tick();
      if (dm_ready) n_data++;
      if (if_ready) begin
        got_if = 1;
        if_req = 0; dm_req = 0;
      end
    end
    chk("t4_if_done",  {31'b0, got_if}, 32'd1);
    chk("t4_n_data",   n_data,          32'd4);
    chk("t4_if_rdata", if_rdata,        32'h20080001);
    tick();

    // Reset during WAIT
    if_req = 1; if_addr = 32'h0;
    tick();
    tick();
    reset = 1; if_req = 0;
    tick();
    chk("t5_mem_en",    {31'b0, mem_en},   32'd0);
    chk("t5_mem_we",    {31'b0, mem_we},   32'd0);
    chk("t5_if_ready",  {31'b0, if_ready}, 32'd0);
    chk("t5_dm_ready",  {31'b0, dm_ready}, 32'd0);
    chk("t5_mem_addr",  mem_addr,  32'd0);
    chk("t5_mem_wdata", mem_wdata, 32'd0);
    chk("t5_if_rdata",  if_rdata,  32'd0);
    chk("t5_dm_rdata",  dm_rdata,  32'd0);
    chk("t5_stall",     {31'b0, stall}, 32'd0);
    reset = 0;
    stray = 0;
    repeat (6) begin
      tick();
      if (if_ready || dm_ready) stray = 1;
    end
    chk("t5_no_stray", {31'b0, stray}, 32'd0);
    // Request set before the accepting edge: ready on the 4th edge
    if_req = 1; if_addr = 32'h4;
    wait_rdy(1'b0, cyc);
    chk("t5_latency", cyc, 32'd4);
    chk("t5_if_rdata_after", if_rdata, 32'h11111111);
    if_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
